move_replay_sequencer: RTL and testbench
========================================

// Module: move_replay_sequencer
// PURPOSE
//   Records every legal player move (row/col select, add_n, fire) applied to the 4x4 x-cell grid.
//   On request, replays those moves in reverse order with add_n inverted, restoring the starting board.
//   It is the initiator side of the grid move interface: it drives row/col/add_n/fire into the x cells.
//   The top level muxes its outputs onto the grid while busy=1.
// PARAMETERS
//   DEPTH    64         max recorded moves (power of 2)
//   PACE     1_000_000  idle cycles between replayed fires (10 ms @ 100 MHz); >=1
//   DEPTH_W  $clog2(DEPTH)  derived; do not override
// PORTS
//   clk        in   1          system clock
//   reset      in   1          synchronous, active-high; clears stack, FSM and flags
//   in_fire    in   1          single-cycle rising-edge strobe of player fire
//   in_nrow    in   1          0 = row move, 1 = column move
//   in_sel     in   4          one-hot row/column select from switches
//   in_addn    in   1          add_n value applied with the move
//   solve_req  in   1          single-cycle pulse: replay whole history
//   row        out  4          one-hot row enable to grid (0 when idle)
//   col        out  4          one-hot column enable to grid (0 when idle)
//   add_n      out  1          inverted recorded add_n during replay
//   fire       out  1          single-cycle fire pulse to grid
//   busy       out  1          1 from the cycle after solve_req is accepted until the cycle done pulses
//   done       out  1          single-cycle pulse when replay finishes
//   depth      out  DEPTH_W+1  number of stored moves
//   overflow   out  1          sticky: a move was dropped because the stack was full
// BEHAVIOUR
//   Reset values: row=col=0, add_n=0, fire=0, busy=0, done=0, depth=0, overflow=0, state=IDLE.
//   Entry format is 4 bits: {nrow, idx[1:0], addn}. idx is the binary encoding of the one-hot in_sel.
//   Record, in IDLE only:
//     - in_fire with in_sel one-hot -> push on the next edge; depth+1.
//     - in_sel not one-hot (0 or multi-hot) -> ignored.
//     - Stack full (depth==DEPTH) -> push dropped, overflow<=1, depth unchanged.
//   FSM states: IDLE, SETUP, FIRE, GAP, DONE.
//     - IDLE: solve_req with depth>0 -> SETUP. solve_req with depth==0 -> DONE.
//     - In IDLE, solve_req has priority over a simultaneous in_fire; that push is dropped.
//     - SETUP (1 cycle): drive row/col from the top entry; add_n = ~entry.addn; fire=0.
//     - FIRE (1 cycle): hold row/col/add_n; fire=1; pop the top entry.
//     - GAP: hold row/col/add_n, fire=0, for PACE cycles.
//       Then go to SETUP if depth>0, else DONE.
//     - DONE (1 cycle): done=1, overflow<=0, then IDLE.
//   row/col outputs: only one of row/col is nonzero, and it is one-hot. Both are 0 in IDLE and DONE.
//   Latency: first fire occurs 2 cycles after solve_req. Fires are spaced PACE+2 cycles apart.
//   in_fire and solve_req are ignored while busy; nothing is recorded during replay.
//   Reset mid-replay aborts on the next edge: outputs go to reset values and history is discarded.
//   Pace counter: DEPTH-independent width, $clog2(PACE+1) bits; never wraps.
// CONFIGURATION
//   MOVE_REPLAY_UNDO_EN
//     - Defined: adds input undo_req (1 bit, single-cycle pulse).
//       In IDLE with depth>0, it runs SETUP -> FIRE -> GAP -> DONE for the top entry only.
//       undo_req with depth==0 is ignored (no done pulse).
//       If solve_req and undo_req arrive together, solve_req wins.
//     - Undefined: no undo_req port; only full replay exists.
// STRUCTURE
//   puzzle_pkg holds:
//     - GRID_N=4
//     - move entry field widths/positions (MV_NROW, MV_IDX, MV_ADDN)
//     - FSM state encodings
//     - onehot_to_idx / idx_to_onehot functions
//   Sub-module move_stack: synchronous LIFO (DEPTH x 4).
//     - push/pop/top/depth/full/empty ports.
//     - push and pop in the same cycle are not allowed.
//   The top FSM, pace counter and output decode live in this module.
// TESTING (PACE=4, DEPTH=4 for the bench)
//   1 Push row1/addn=0, col2/addn=1, then solve_req.
//     -> fire #1: col=0100, row=0, add_n=0.
//     -> fire #2: row=0010, add_n=1.
//     -> fires 6 cycles apart; done pulses once; depth=0.
//   2 in_fire with in_sel=0000, then with 0110 -> depth stays 0. solve_req -> done the next cycle, no fire.
//   3 5 legal pushes -> depth=4, overflow=1. Replay fires 4 times, then overflow=0.
//   4 in_fire together with solve_req, depth=2 -> exactly 2 fires; depth 0 after done.
//     in_fire during busy -> not recorded.
//   5 reset asserted between fire #1 and fire #2 -> next cycle busy=0, fire=0, row=col=0, depth=0.
//   6 (MOVE_REPLAY_UNDO_EN) depth=3, undo_req -> one fire of the last move inverted, done, depth=2.

Source files
------------

// File: rtl/puzzle_pkg.sv
// Shared types for the x-cell puzzle: move entry layout, replay FSM states and
// one-hot/index helpers used by move_replay_sequencer and move_stack.
package puzzle_pkg;

  localparam int GRID_N = 4;
  localparam int IDX_W  = 2;
  localparam int MV_W   = 4;

  // Bit positions inside a stored move {nrow, idx[1:0], addn}
  localparam int MV_NROW = 3;
  localparam int MV_IDX  = 1;
  localparam int MV_ADDN = 0;

  typedef struct packed {
    logic             nrow;
    logic [IDX_W-1:0] idx;
    logic             addn;
  } move_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_FIRE  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic is_onehot(input logic [GRID_N-1:0] v);
    return (v != '0) && ((v & (v - GRID_N'(1))) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [GRID_N-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < GRID_N; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [GRID_N-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return GRID_N'(1) << idx;
  endfunction

endpackage

// File: rtl/move_replay_sequencer_move_stack.sv
// Synchronous LIFO of recorded moves. Callers must not push and pop in the same
// cycle; a push while full or a pop while empty leaves the stack unchanged.
module move_stack
  import puzzle_pkg::*;
#(
  parameter  int DEPTH   = 64,
  localparam int DEPTH_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  move_t            push_data,
  output move_t            top,
  output logic [DEPTH_W:0] depth,
  output logic             full,
  output logic             empty
);

  localparam logic [DEPTH_W:0] FULL_CNT = DEPTH[DEPTH_W:0];

  move_t              mem [DEPTH];
  logic [DEPTH_W-1:0] wr_idx;
  logic [DEPTH_W-1:0] top_idx;

  assign wr_idx  = depth[DEPTH_W-1:0];
  assign top_idx = wr_idx - DEPTH_W'(1);
  assign top     = mem[top_idx];
  assign full    = (depth == FULL_CNT);
  assign empty   = (depth == '0);

  // Storage is not reset: depth alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_idx] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      depth <= '0;
    end else if (push && !full) begin
      depth <= depth + (DEPTH_W+1)'(1);
    end else if (pop && !empty) begin
      depth <= depth - (DEPTH_W+1)'(1);
    end
  end

endmodule

// File: rtl/move_replay_sequencer.sv
// Records legal player moves and replays them in reverse with add_n inverted.
// Optional MOVE_REPLAY_UNDO_EN adds undo_req to reverse only the latest move.
//
// Handshake: in_fire, solve_req (and undo_req) are single-cycle strobes sampled
// only in IDLE; fire and done are single-cycle pulses; busy covers SETUP..DONE.
module move_replay_sequencer
  import puzzle_pkg::*;
#(
  parameter  int DEPTH   = 64,
  parameter  int PACE    = 1_000_000,
  localparam int DEPTH_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_fire,
  input  logic              in_nrow,
  input  logic [GRID_N-1:0] in_sel,
  input  logic              in_addn,
  input  logic              solve_req,
`ifdef MOVE_REPLAY_UNDO_EN
  input  logic              undo_req,
`endif
  output logic [GRID_N-1:0] row,
  output logic [GRID_N-1:0] col,
  output logic              add_n,
  output logic              fire,
  output logic              busy,
  output logic              done,
  output logic [DEPTH_W:0]  depth,
  output logic              overflow,
  output state_t            state
);

  localparam int PACE_W = $clog2(PACE + 1);

  state_t             state_q, state_d;
  move_t              top_entry, cur_q, push_entry;
  logic               stack_full, stack_empty;
  logic               push, pop, drop_full;
  logic               undo_go, undo_q;
  logic [PACE_W-1:0]  pace_q;

`ifdef MOVE_REPLAY_UNDO_EN
  assign undo_go = undo_req;
`else
  assign undo_go = 1'b0;
`endif

  assign push_entry = '{nrow: in_nrow, idx: onehot_to_idx(in_sel), addn: in_addn};
  assign state      = state_q;

  move_stack #(.DEPTH(DEPTH)) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (push_entry),
    .top       (top_entry),
    .depth     (depth),
    .full      (stack_full),
    .empty     (stack_empty)
  );

  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    pop       = 1'b0;
    drop_full = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A request wins over a same-cycle fire; that fire is discarded.
        if (solve_req) begin
          state_d = stack_empty ? S_DONE : S_SETUP;
        end else if (undo_go && !stack_empty) begin
          state_d = S_SETUP;
        end else if (in_fire && is_onehot(in_sel)) begin
          push      = !stack_full;
          drop_full = stack_full;
        end
      end
      S_SETUP: state_d = S_FIRE;
      S_FIRE: begin
        pop     = 1'b1;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (pace_q == PACE_W'(PACE - 1)) begin
          state_d = (undo_q || stack_empty) ? S_DONE : S_SETUP;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    row   = '0;
    col   = '0;
    add_n = 1'b0;
    if (state_q == S_SETUP || state_q == S_FIRE || state_q == S_GAP) begin
      if (cur_q.nrow) col = idx_to_onehot(cur_q.idx);
      else            row = idx_to_onehot(cur_q.idx);
      add_n = ~cur_q.addn;
    end
  end

  assign fire = (state_q == S_FIRE);
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cur_q    <= '0;
      pace_q   <= '0;
      undo_q   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      // Latch the move being replayed; the stack top moves on after the pop.
      if (state_d == S_SETUP) cur_q <= top_entry;
      if (state_q == S_FIRE)     pace_q <= '0;
      else if (state_q == S_GAP) pace_q <= pace_q + PACE_W'(1);
      if (state_q == S_IDLE) undo_q <= undo_go && !solve_req;
      if (drop_full)             overflow <= 1'b1;
      else if (state_q == S_DONE) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_move_replay_sequencer.sv
// Directed bench for move_replay_sequencer with DEPTH=4, PACE=4; replay fires are
// scored against a queue of hand-computed {row, col, add_n} values.
module tb_move_replay_sequencer;
  import puzzle_pkg::*;

  localparam int DEPTH = 4;
  localparam int PACE  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_fire = 1'b0;
  logic       in_nrow = 1'b0;
  logic [3:0] in_sel = 4'b0000;
  logic       in_addn = 1'b0;
  logic       solve_req = 1'b0;
`ifdef MOVE_REPLAY_UNDO_EN
  logic       undo_req = 1'b0;
`endif
  logic [3:0] row, col;
  logic       add_n, fire, busy, done, overflow;
  logic [2:0] depth;
  state_t     dut_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [8:0] exp_q[$];

  move_replay_sequencer #(.DEPTH(DEPTH), .PACE(PACE)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_fire   (in_fire),
    .in_nrow   (in_nrow),
    .in_sel    (in_sel),
    .in_addn   (in_addn),
    .solve_req (solve_req),
`ifdef MOVE_REPLAY_UNDO_EN
    .undo_req  (undo_req),
`endif
    .row       (row),
    .col       (col),
    .add_n     (add_n),
    .fire      (fire),
    .busy      (busy),
    .done      (done),
    .depth     (depth),
    .overflow  (overflow),
    .state     (dut_state)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Drivers: every task starts and ends 1 time unit after a rising edge
  task automatic drive_fire(input logic nrow, input logic [3:0] sel, input logic addn);
    in_nrow = nrow;
    in_sel  = sel;
    in_addn = addn;
    in_fire = 1'b1;
    @(posedge clk);
    #1 in_fire = 1'b0;
  endtask

  task automatic run_replay(input string tag, input int n, input int exp_depth,
                            input bit use_undo, input bit fire_with_req, input bit fire_during);
    int   c0, last, seen, exp_done;
    bit   got_done;
    logic [8:0] e;
    if (fire_with_req) begin
      in_nrow = 1'b0; in_sel = 4'b0001; in_addn = 1'b0; in_fire = 1'b1;
    end
`ifdef MOVE_REPLAY_UNDO_EN
    if (use_undo) undo_req = 1'b1;
    else          solve_req = 1'b1;
`else
    if (use_undo) $display("note: undo not built, using solve_req");
    solve_req = 1'b1;
`endif
    c0 = cyc;
    @(posedge clk);
    #1;
    solve_req = 1'b0;
`ifdef MOVE_REPLAY_UNDO_EN
    undo_req = 1'b0;
`endif
    in_fire = 1'b0;
    seen = 0; got_done = 1'b0; last = c0;
    for (int k = 0; k < 200 && !got_done; k++) begin
      @(negedge clk);
      if (fire_during && k == 3) begin
        in_nrow = 1'b1; in_sel = 4'b1000; in_fire = 1'b1;
      end else begin
        in_fire = 1'b0;
      end
      if (fire) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check({tag, " fire_rc_addn"}, 32'({row, col, add_n}), 32'(e));
        end else begin
          check({tag, " unexpected_fire"}, 32'(1), 32'(0));
        end
        check({tag, " fire_spacing"}, 32'(cyc - last), 32'((seen == 0) ? 2 : PACE + 2));
        check({tag, " busy_at_fire"}, 32'(busy), 32'(1));
        last = cyc;
        seen++;
      end
      if (done) begin
        got_done = 1'b1;
        exp_done = (n == 0) ? c0 + 1 : last + PACE + 1;
        check({tag, " done_cycle"}, 32'(cyc - c0), 32'(exp_done - c0));
        check({tag, " rowcol_at_done"}, 32'({row, col}), 32'(0));
        check({tag, " depth_at_done"}, 32'(depth), 32'(exp_depth));
      end
    end
    in_fire = 1'b0;
    check({tag, " fire_count"}, 32'(seen), 32'(n));
    check({tag, " done_seen"}, 32'(got_done), 32'(1));
    @(negedge clk);
    check({tag, " idle_after"}, 32'({busy, done, fire, overflow}), 32'(0));
    check({tag, " depth_after"}, 32'(depth), 32'(exp_depth));
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit got;
    do_reset();

    // Reset values
    @(negedge clk);
    check("rst outputs", 32'({row, col, add_n, fire, busy, done, overflow}), 32'(0));
    check("rst depth", 32'(depth), 32'(0));
    check("rst state", 32'(dut_state), 32'(S_IDLE));
    @(posedge clk); #1;

    // 1: two moves, full replay
    drive_fire(1'b0, 4'b0010, 1'b0);
    drive_fire(1'b1, 4'b0100, 1'b1);
    check("t1 depth", 32'(depth), 32'(2));
    exp_q.push_back(9'b0000_0100_0);
    exp_q.push_back(9'b0010_0000_1);
    run_replay("t1", 2, 0, 1'b0, 1'b0, 1'b0);

    // 2: illegal selects ignored, empty replay
    drive_fire(1'b0, 4'b0000, 1'b0);
    drive_fire(1'b0, 4'b0110, 1'b1);
    check("t2 depth", 32'(depth), 32'(0));
    run_replay("t2", 0, 0, 1'b0, 1'b0, 1'b0);

    // 3: overflow on fifth push, cleared by done
    drive_fire(1'b0, 4'b0001, 1'b1);
    drive_fire(1'b1, 4'b1000, 1'b0);
    drive_fire(1'b0, 4'b0100, 1'b0);
    drive_fire(1'b1, 4'b0010, 1'b1);
    drive_fire(1'b0, 4'b1000, 1'b1);
    check("t3 depth", 32'(depth), 32'(4));
    check("t3 overflow", 32'(overflow), 32'(1));
    exp_q.push_back(9'b0000_0010_0);
    exp_q.push_back(9'b0100_0000_1);
    exp_q.push_back(9'b0000_1000_1);
    exp_q.push_back(9'b0001_0000_0);
    run_replay("t3", 4, 0, 1'b0, 1'b0, 1'b0);

    // 4: fire with solve_req dropped, fire while busy not recorded
    drive_fire(1'b1, 4'b0001, 1'b0);
    drive_fire(1'b0, 4'b1000, 1'b1);
    check("t4 depth", 32'(depth), 32'(2));
    exp_q.push_back(9'b1000_0000_0);
    exp_q.push_back(9'b0000_0001_1);
    run_replay("t4", 2, 0, 1'b0, 1'b1, 1'b1);

    // 5: reset between fires aborts replay
    drive_fire(1'b0, 4'b0001, 1'b0);
    drive_fire(1'b0, 4'b0010, 1'b0);
    solve_req = 1'b1;
    @(posedge clk); #1 solve_req = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (fire) got = 1'b1;
    end
    check("t5 first_fire", 32'(got), 32'(1));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t5 abort_outputs", 32'({busy, fire, row, col}), 32'(0));
    check("t5 abort_depth", 32'(depth), 32'(0));
    check("t5 abort_state", 32'(dut_state), 32'(S_IDLE));
    reset = 1'b0;
    @(posedge clk); #1;

`ifdef MOVE_REPLAY_UNDO_EN
    // 6: undo reverses only the latest move
    drive_fire(1'b0, 4'b0001, 1'b0);
    drive_fire(1'b1, 4'b0100, 1'b1);
    drive_fire(1'b0, 4'b0010, 1'b1);
    check("t6 depth", 32'(depth), 32'(3));
    exp_q.push_back(9'b0010_0000_0);
    run_replay("t6", 1, 2, 1'b1, 1'b0, 1'b0);
`endif

    check("scoreboard empty", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
